// File: rtl/ifft_output_buffer.sv
// Ping-pong frame buffer for IFFT output: scales each sample's real part, packs
// LANES samples per row, and serves one registered row per cycle from the read bank.
module ifft_output_buffer #(
    parameter int SIZE        = 16,
    parameter int OUTPUT_SIZE = 512,
    parameter int SAMPLES     = 2048
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         ce,
    input  logic                                         sync,
    input  logic [31:0]                                  sample_in,
    input  logic [3:0]                                   scale_shift,
    input  logic [$clog2(SAMPLES*SIZE/OUTPUT_SIZE)-1:0]  output_index,
    input  logic                                         frame_ack,
    output logic [OUTPUT_SIZE-1:0]                       data_out,
    output logic                                         frame_done,
    output logic                                         frame_valid,
    output logic                                         overrun,
    output logic                                         sync_err
);

    localparam int ROWS      = SAMPLES * SIZE / OUTPUT_SIZE;
    localparam int LANES     = OUTPUT_SIZE / SIZE;
    localparam int CW        = $clog2(SAMPLES);
    localparam int LW        = $clog2(LANES);
    localparam int RW        = $clog2(ROWS);
    localparam int MAX_SHIFT = 11;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            wbank_reg, wbank_next;
    logic [3:0]      shift_reg, shift_next;
    logic            frame_done_reg, frame_done_next;
    logic            frame_valid_reg, frame_valid_next;
    logic            overrun_reg, overrun_next;
    logic            sync_err_reg, sync_err_next;

    logic            wr_en;
    logic [CW-1:0]   wr_idx;
    logic [3:0]      wr_shift;
    logic [3:0]      shift_in;
    logic [LW-1:0]   wr_lane;
    logic [RW-1:0]   wr_row;
    logic [SIZE-1:0] wr_val;

    logic signed [16:0] real_ext;
    logic signed [16:0] rnd;
    logic signed [16:0] sum;
    logic signed [16:0] scaled;

    logic unused_imag;
    assign unused_imag = ^sample_in[15:0];

    assign shift_in = (scale_shift > 4'(MAX_SHIFT)) ? 4'(MAX_SHIFT) : scale_shift;
    assign wr_lane  = wr_idx[LW-1:0];
    assign wr_row   = wr_idx[CW-1:LW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            wbank_reg       <= 1'b0;
            shift_reg       <= '0;
            frame_done_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            sync_err_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            wbank_reg       <= wbank_next;
            shift_reg       <= shift_next;
            frame_done_reg  <= frame_done_next;
            frame_valid_reg <= frame_valid_next;
            overrun_reg     <= overrun_next;
            sync_err_reg    <= sync_err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        wbank_next       = wbank_reg;
        shift_next       = shift_reg;
        frame_done_next  = 1'b0;
        frame_valid_next = frame_valid_reg & ~frame_ack;
        overrun_next     = overrun_reg;
        sync_err_next    = sync_err_reg;
        wr_en            = 1'b0;
        wr_idx           = cnt_reg;
        wr_shift         = shift_reg;
        case (state_reg)
            IDLE: begin
                if (ce && sync) begin
                    wr_en      = 1'b1;
                    wr_idx     = '0;
                    wr_shift   = shift_in;
                    shift_next = shift_in;
                    cnt_next   = CW'(1);
                    state_next = FILL;
                end
            end
            FILL: begin
                if (ce) begin
                    wr_en = 1'b1;
                    if (sync) begin
                        // Restart: the partial frame is simply overwritten.
                        sync_err_next = 1'b1;
                        wr_idx        = '0;
                        wr_shift      = shift_in;
                        shift_next    = shift_in;
                        cnt_next      = CW'(1);
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                        if (cnt_reg == CW'(SAMPLES - 1)) begin
                            state_next       = IDLE;
                            wbank_next       = ~wbank_reg;
                            frame_done_next  = 1'b1;
                            frame_valid_next = 1'b1;
                            if (frame_valid_reg && !frame_ack)
                                overrun_next = 1'b1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Round-half-up: bias by half an output LSB, then arithmetic shift.
    always_comb begin
        real_ext = {sample_in[31], sample_in[31:16]};
        rnd      = (wr_shift == 4'd0) ? 17'sd0 : (17'sd1 <<< (wr_shift - 4'd1));
        sum      = real_ext + rnd;
        scaled   = sum >>> wr_shift;
        wr_val   = scaled[SIZE-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [SIZE-1:0] mem [2*ROWS];
            logic [SIZE-1:0] rd_reg;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_lane == LW'(gi)))
                    mem[{wbank_reg, wr_row}] <= wr_val;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    rd_reg <= '0;
                else
                    rd_reg <= mem[{~wbank_reg, output_index}];
            end

            assign data_out[gi*SIZE +: SIZE] = rd_reg;
        end
    endgenerate

    assign frame_done  = frame_done_reg;
    assign frame_valid = frame_valid_reg;
    assign overrun     = overrun_reg;
    assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_ifft_output_buffer.sv
// Randomized self-checking bench for ifft_output_buffer against a frame-level
// reference model (sample list -> scaled values -> row/lane placement).
module tb_ifft_output_buffer;

    localparam int N     = 2048;
    localparam int ROWS  = 64;
    localparam int LANES = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         sync;
    logic [31:0]  sample_in;
    logic [3:0]   scale_shift;
    logic [5:0]   output_index;
    logic         frame_ack;
    logic [511:0] data_out;
    logic         frame_done;
    logic         frame_valid;
    logic         overrun;
    logic         sync_err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    int           src [N];
    logic [15:0]  exp_cur [N];
    logic [15:0]  rd_frame [N];
    logic [511:0] captured [ROWS];

    ifft_output_buffer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ce           (ce),
        .sync         (sync),
        .sample_in    (sample_in),
        .scale_shift  (scale_shift),
        .output_index (output_index),
        .frame_ack    (frame_ack),
        .data_out     (data_out),
        .frame_done   (frame_done),
        .frame_valid  (frame_valid),
        .overrun      (overrun),
        .sync_err     (sync_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done === 1'b1)
            done_cnt++;
    end

    // Reference scaling: round(x / 2^s) with ties toward +inf, shift clamped to 11.
    function automatic logic [15:0] ref_scale(input int x, input int s);
        int  se;
        real v;
        int  r;
        se = (s > 11) ? 11 : s;
        if (se == 0)
            return x[15:0];
        v = $floor(real'(x) / real'(1 << se) + 0.5);
        r = $rtoi(v);
        return r[15:0];
    endfunction

    function automatic logic [511:0] exp_row(input int r);
        logic [511:0] e;
        for (int l = 0; l < LANES; l++)
            e[16*l +: 16] = rd_frame[r*LANES + l];
        return e;
    endfunction

    task automatic idle_cycle();
        ce          = 1'b0;
        sync        = 1'($urandom);
        sample_in   = $urandom;
        scale_shift = 4'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic push(input int val, input bit s, input int shift, input bit ack);
        logic [31:0] w;
        w           = val;
        ce          = 1'b1;
        sync        = s;
        sample_in   = {w[15:0], 16'($urandom)};
        scale_shift = 4'(shift);
        frame_ack   = ack;
        @(posedge clk); #1;
        ce        = 1'b0;
        sync      = 1'b0;
        frame_ack = 1'b0;
    endtask

    // Drives one complete frame from src[]; later samples carry a random
    // scale_shift that must be ignored in favour of the one latched at sync.
    task automatic send_frame(input int shift, input int gap_pct, input bit ack_last);
        for (int k = 0; k < N; k++) begin
            while ($urandom_range(99) < gap_pct)
                idle_cycle();
            exp_cur[k] = ref_scale(src[k], shift);
            if (k == 0)
                push(src[k], 1'b1, shift, 1'b0);
            else
                push(src[k], 1'b0, $urandom_range(15), ack_last && (k == N - 1));
        end
        for (int k = 0; k < N; k++)
            rd_frame[k] = exp_cur[k];
    endtask

    task automatic read_row(input int r, output logic [511:0] d);
        ce           = 1'b0;
        output_index = 6'(r);
        @(posedge clk); #1;
        d = data_out;
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    task automatic random_src();
        for (int k = 0; k < N; k++)
            src[k] = int'($urandom_range(65535)) - 32768;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ce = 1'b0; sync = 1'b0; sample_in = '0; scale_shift = '0;
        output_index = '0; frame_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data_out, frame_done, frame_valid, overrun, sync_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data_out=%h flags=%b%b%b%b expected all 0",
                     data_out, frame_done, frame_valid, overrun, sync_err);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({frame_done, frame_valid, overrun, sync_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_hold: flags=%b%b%b%b expected 0000",
                     frame_done, frame_valid, overrun, sync_err);
        end
        $display("reset: done");
    endtask

    task automatic test_ramp();
        logic [511:0] d;
        int           d0;
        for (int k = 0; k < N; k++)
            src[k] = k;
        d0 = done_cnt;
        send_frame(0, 0, 1'b0);
        checks++;
        if (frame_done !== 1'b1 || frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL ramp_done: frame_done=%b frame_valid=%b expected 1 1", frame_done, frame_valid);
        end
        read_row(5, d);
        checks++;
        if (d[15:0] !== 16'd160 || d[511:496] !== 16'd191) begin
            errors++;
            $display("FAIL ramp_row5: lane0=%0d lane31=%0d expected 160 191", d[15:0], d[511:496]);
        end
        checks++;
        if (frame_done !== 1'b0 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL ramp_pulse: frame_done=%b pulses=%0d expected 0 and 1 pulse", frame_done, done_cnt - d0);
        end
        read_row(63, d);
        checks++;
        if (d[511:496] !== 16'd2047) begin
            errors++;
            $display("FAIL ramp_row63: lane31=%0d expected 2047", d[511:496]);
        end
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            checks++;
            if (d !== exp_row(r)) begin
                errors++;
                $display("FAIL ramp_rows: row %0d got %h expected %h", r, d, exp_row(r));
            end
        end
        do_ack();
        checks++;
        if (frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL ramp_ack: frame_valid=%b expected 0", frame_valid);
        end
        $display("ramp: frame checked, shift 0");
    endtask

    task automatic test_scaling();
        logic [511:0] d;
        random_src();
        src[0] = 6; src[1] = -7; src[2] = 32767; src[3] = -32768;
        send_frame(2, 0, 1'b0);
        read_row(0, d);
        checks++;
        if (d[63:0] !== {16'hE000, 16'd8192, 16'hFFFE, 16'd2}) begin
            errors++;
            $display("FAIL scale_shift2: lanes3..0=%h expected e0002000fffe0002", d[63:0]);
        end
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            checks++;
            if (d !== exp_row(r)) begin
                errors++;
                $display("FAIL scale_rows: row %0d got %h expected %h", r, d, exp_row(r));
            end
        end
        do_ack();
        $display("scaling: frame checked, shift 2");
    endtask

    task automatic test_gaps();
        logic [511:0] d;
        int           d0;
        int           sh;
        random_src();
        sh = 14;
        send_frame(sh, 0, 1'b0);
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            captured[r] = d;
        end
        do_ack();
        d0 = done_cnt;
        send_frame(sh, 50, 1'b0);
        idle_cycle();
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL gap_done_count: pulses=%0d expected 1", done_cnt - d0);
        end
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            checks++;
            if (d !== captured[r] || d !== exp_row(r)) begin
                errors++;
                $display("FAIL gap_rows: row %0d got %h expected %h", r, d, exp_row(r));
            end
        end
        $display("gaps: frame checked, shift %0d, 50%% ce duty", sh);
    endtask

    task automatic test_back_to_back();
        logic [511:0] d;
        int           d0;
        d0 = done_cnt;
        random_src();
        send_frame($urandom_range(11), 0, 1'b0);
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b expected 1", overrun);
        end
        random_src();
        send_frame($urandom_range(11), 0, 1'b0);
        idle_cycle();
        checks++;
        if (done_cnt - d0 != 2 || frame_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done: pulses=%0d frame_valid=%b expected 2 1", done_cnt - d0, frame_valid);
        end
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            checks++;
            if (d !== exp_row(r)) begin
                errors++;
                $display("FAIL b2b_rows: row %0d got %h expected %h", r, d, exp_row(r));
            end
        end
        $display("back_to_back: two frames, overrun=%b", overrun);
    endtask

    task automatic test_sync_err();
        logic [511:0] d;
        int           d0;
        d0 = done_cnt;
        for (int k = 0; k < 1000; k++)
            push(int'($urandom_range(65535)) - 32768, k == 0, 3, 1'b0);
        checks++;
        if (sync_err !== 1'b0) begin
            errors++;
            $display("FAIL sync_err_early: sync_err=%b expected 0", sync_err);
        end
        random_src();
        send_frame($urandom_range(11), 0, 1'b0);
        idle_cycle();
        checks++;
        if (sync_err !== 1'b1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL sync_err_set: sync_err=%b pulses=%0d expected 1 1", sync_err, done_cnt - d0);
        end
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            checks++;
            if (d !== exp_row(r)) begin
                errors++;
                $display("FAIL sync_rows: row %0d got %h expected %h", r, d, exp_row(r));
            end
        end
        $display("sync_err: restart at index 1000 handled");
    endtask

    task automatic test_reset_mid();
        logic [511:0] d;
        for (int k = 0; k < 1500; k++)
            push(k, k == 0, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        checks++;
        if ({data_out, frame_done, frame_valid, overrun, sync_err} !== '0) begin
            errors++;
            $display("FAIL reset_mid: data_out=%h flags=%b%b%b%b expected all 0",
                     data_out, frame_done, frame_valid, overrun, sync_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        random_src();
        send_frame($urandom_range(11), 0, 1'b0);
        checks++;
        if (frame_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_frame: frame_valid=%b overrun=%b expected 1 0", frame_valid, overrun);
        end
        for (int r = 0; r < ROWS; r++) begin
            read_row(r, d);
            checks++;
            if (d !== exp_row(r)) begin
                errors++;
                $display("FAIL post_reset_rows: row %0d got %h expected %h", r, d, exp_row(r));
            end
        end
        random_src();
        send_frame($urandom_range(15), 0, 1'b1);
        idle_cycle();
        checks++;
        if (frame_valid !== 1'b1 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ack_at_swap: frame_valid=%b overrun=%b expected 1 0", frame_valid, overrun);
        end
        read_row($urandom_range(63), d);
        checks++;
        if (d !== exp_row(int'(output_index))) begin
            errors++;
            $display("FAIL ack_at_swap_row: row %0d got %h expected %h", output_index, d, exp_row(int'(output_index)));
        end
        $display("reset_mid: recovery and ack-at-swap checked");
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_scaling();
        test_gaps();
        test_back_to_back();
        test_sync_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifft_output_buffer.md
# ifft_output_buffer

Collects the time-domain sample stream from the inverse FFT at the back of the audio pipeline, after pitch shift, and repacks it into 512-bit rows that the host reads with the STE instruction. It mirrors the input-side packing, so a frame written by LDE rows and a frame read back by STE rows share the same lane layout. Two frame banks (ping-pong) let the next IFFT frame fill while software drains the previous one. Each sample's real part is scaled by a programmable arithmetic right shift with rounding.

## Interface
- SIZE, 16, bits per stored sample
- OUTPUT_SIZE, 512, bits per read row
- SAMPLES, 2048, samples per frame; ROWS = SAMPLES*SIZE/OUTPUT_SIZE (64), LANES = OUTPUT_SIZE/SIZE (32)

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ce  in  1  sample valid; sample_in/sync are sampled only when ce=1
- sync  in  1  qualified by ce; marks sample 0 of a frame
- sample_in  in  32  {real[31:16], imag[15:0]} from IFFT; imag ignored
- scale_shift  in  4  right-shift amount, 0..11, latched at frame start
- output_index  in  $clog2(ROWS)  row to read from read bank
- frame_ack  in  1  software consumed read bank; clears frame_valid
- data_out  out  OUTPUT_SIZE  registered read data
- frame_done  out  1  one-cycle pulse on frame completion/bank swap
- frame_valid  out  1  read bank holds an unacknowledged complete frame
- overrun  out  1  sticky: frame completed while frame_valid=1
- sync_err  out  1  sticky: sync seen mid-frame

## Operation
- States: IDLE, FILL. Counter cnt (11 bits) = next sample index; wbank/rbank = 1-bit bank pointers (rbank = ~wbank).
- IDLE: ce&sync -> latch scale_shift, store sample as index 0, cnt=1, go FILL. ce without sync: sample dropped.
- FILL: each ce stores at index cnt, cnt++. ce&sync in FILL: set sync_err, discard partial frame, store sample as index 0, cnt=1, re-latch scale_shift, stay FILL.
- Storing index 2047: swap banks at that edge, go IDLE, frame_done=1 next cycle, frame_valid=1; if frame_valid was already 1 (and no frame_ack this cycle) set overrun. Swap always happens; unread frame is lost.
- Placement: index k -> row k/LANES, lane k%LANES, lane l at bits [16l+15:16l].
- Scaling: s = latched shift. s=0: value = real. s>0: 17-bit signed sum real + 2^(s-1), arithmetic shift right by s, low 16 bits (always fits, no saturation). scale_shift >11 treated as 11.
- frame_ack clears frame_valid the next edge; ack concurrent with swap: frame_valid stays 1, no overrun.
- Reads: data_out <= bank[rbank][output_index] every cycle, no enable.
- Storage not reset; contents undefined until first full frame.

## Timing
- Reset: state IDLE, cnt=0, wbank=0, data_out=0, frame_done=0, frame_valid=0, overrun=0, sync_err=0.
- Write latency: sample accepted at edge t is visible through the read path only after the frame's bank swap.
- frame_done high exactly one cycle, the cycle after the last sample's edge; rbank already switched then.
- Read latency 1: output_index at edge t -> data_out after edge t+1, using rbank value before edge t+1.
- ce gaps anywhere in a frame are allowed; cnt holds.
- Back-to-back frames: sync on the cycle frame_done is high is accepted (IDLE).
- Reset mid-frame: partial frame discarded, both banks invalid, all flags clear.

## Test plan
- Reset with ce=0 -> all outputs 0, frame_valid=0; 5 cycles later still 0.
- Frame with real=k for k=0..2047, shift 0, continuous ce -> frame_done one cycle after sample 2047; row 5 reads lane 0=160, lane 31=191; row 63 lane 31=2047.
- shift=2, inputs 6, -7, 32767, -32768 -> 2, -2, 8192, -8192; shift=0 passes values unchanged.
- Random ce gaps (~50% duty) across a frame -> identical rows to gap-free run; frame_done count=1.
- Second frame without frame_ack -> overrun=1, rbank shows frame 2; sync at index 1000 -> sync_err=1, frame completes 2048 samples later.
- rst_n low at index 1500 -> flags 0, IDLE; subsequent full frame reads correctly.
